aes_key_expand: RTL and testbench

Iterative AES-128 key-expansion engine that sits directly upstream of the round datapath. It accepts one 128-bit cipher key and emits the 11 round keys (rounds 0..10) in order over a valid/ready stream, one per accepted handshake. The FIPS-197 SubWord step is computed by four instances of the existing `aes_sbox` byte-substitution module. An optional on-chip store keeps all round keys for random-access reuse, for example by a decryption path.

---
 rtl/aes_key_expand.sv | 163 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: one round key per valid/ready handshake.
// Optional round-key store enabled by defining AES_KEY_STORE_EN.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte of the table.
    assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] round_key,
    output logic         round_key_valid,
    input  logic         round_key_ready,
    output logic [3:0]   round_idx,
    output logic         done,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data
);
    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_key_hs;
    logic         w_rk_hs;
    logic         w_last;
    logic         w_adv;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_next;
    logic [7:0]   w_rcon_nxt;

    assign w_key_hs = key_valid && (r_state == IDLE);
    assign w_rk_hs  = round_key_ready && (r_state == EMIT);
    assign w_last   = (r_round_idx == 4'd10);
    assign w_adv    = w_rk_hs && !w_last;

    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .i_byte(w_rot[g*8 +: 8]),
            .o_byte(w_sub[g*8 +: 8])
        );
    end

    assign w_t    = w_sub ^ {r_rcon, 24'h0};
    assign w_n0   = r_round_key[127:96] ^ w_t;
    assign w_n1   = w_n0 ^ r_round_key[95:64];
    assign w_n2   = w_n1 ^ r_round_key[63:32];
    assign w_n3   = w_n2 ^ r_round_key[31:0];
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_key_hs) w_state_nxt = EMIT;
            EMIT: if (w_rk_hs && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_round_key <= '0;
            r_round_idx <= '0;
            r_rcon      <= 8'h01;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_rk_hs && w_last;
            if (w_key_hs) begin
                r_round_key <= key_in;
                r_round_idx <= 4'd0;
                r_rcon      <= 8'h01;
            end else if (w_adv) begin
                r_round_key <= w_next;
                r_round_idx <= r_round_idx + 4'd1;
                r_rcon      <= w_rcon_nxt;
            end
        end
    end

    assign key_ready       = (r_state == IDLE);
    assign round_key_valid = (r_state == EMIT);
    assign round_key       = r_round_key;
    assign round_idx       = r_round_idx;
    assign done            = r_done;

`ifdef AES_KEY_STORE_EN
    logic [127:0] r_store [0:10];
    logic [127:0] r_rd_data;
    logic [3:0]   w_wr_idx;

    assign w_wr_idx = r_round_idx + 4'd1;

    // Each slot mirrors the round key register at the moment it is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) r_store[i] <= '0;
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (w_key_hs && i == 0) begin
                    r_store[i] <= key_in;
                end else if (w_adv && 4'(i) == w_wr_idx) begin
                    r_store[i] <= w_next;
                end
            end
            if (rk_rd_addr <= 4'd10) r_rd_data <= r_store[rk_rd_addr];
            else r_rd_data <= '0;
        end
    end

    assign rk_rd_data = r_rd_data;
`else
    logic w_unused_rd_addr;

    assign w_unused_rd_addr = ^rk_rd_addr;
    assign rk_rd_data       = '0;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed-vector bench for aes_key_expand: FIPS-197 and zero keys,
// backpressure, ignored keys, mid-sequence reset, and the round-key store.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic         round_key_ready;
    logic [3:0]   round_idx;
    logic         done;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .round_key(round_key),
        .round_key_valid(round_key_valid),
        .round_key_ready(round_key_ready),
        .round_idx(round_idx),
        .done(done),
        .rk_rd_addr(rk_rd_addr),
        .rk_rd_data(rk_rd_data)
    );

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
        bit           bp;
        bit           inj;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] got [0:10];
    int           done_cyc;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_seq(input logic [127:0] k, input bit bp, input bit inj);
        int           nhs;
        bit           pstall;
        bit           fin;
        logic [127:0] pk;
        logic [3:0]   pi;
        @(negedge clk);
        round_key_ready = 1'b1;
        chk("key_ready_idle", 128'(key_ready), 128'd1);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_in    = '0;
        nhs = 0;
        pstall = 0;
        fin = 0;
        done_cyc = -1;
        pk = '0;
        pi = '0;
        for (int cnt = 1; cnt <= 300 && !fin; cnt++) begin
            @(negedge clk);
            if (nhs == 11) begin
                chk("done_pulse", 128'(done), 128'd1);
                chk("key_ready_done", 128'(key_ready), 128'd1);
                done_cyc = cnt;
                fin = 1;
            end else begin
                chk("valid_emit", 128'(round_key_valid), 128'd1);
                chk("key_ready_emit", 128'(key_ready), 128'd0);
                chk("done_low", 128'(done), 128'd0);
                chk("idx_order", 128'(round_idx), 128'(nhs));
                if (pstall) begin
                    chk("hold_key", round_key, pk);
                    chk("hold_idx", 128'(round_idx), 128'(pi));
                end
                if (inj) begin
                    key_valid = (cnt == 3);
                    key_in    = (cnt == 3) ? ~k : '0;
                end
                round_key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                pstall = !round_key_ready;
                pk = round_key;
                pi = round_idx;
                if (round_key_ready) begin
                    got[nhs] = round_key;
                    nhs++;
                end
            end
        end
        key_valid = 1'b0;
        round_key_ready = 1'b1;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d handshakes want 11", nhs);
        end
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{FIPS, fips_rk[1], fips_rk[10], 1'b0, 1'b0};
        vecs[1] = '{128'h0, 128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0, 1'b0};
        vecs[2] = '{FIPS, fips_rk[1], fips_rk[10], 1'b1, 1'b0};
        vecs[3] = '{FIPS, fips_rk[1], fips_rk[10], 1'b0, 1'b1};
        vecs[4] = '{128'h0, 128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1, 1'b0};

        rst_n = 1'b0;
        key_in = '0;
        key_valid = 1'b0;
        round_key_ready = 1'b0;
        rk_rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(round_key_valid), 128'd0);
        chk("rst_key", round_key, 128'd0);
        chk("rst_idx", 128'(round_idx), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rd_data", rk_rd_data, 128'd0);
        // Ready while not valid must not disturb anything.
        round_key_ready = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_noop", 128'(round_key_valid), 128'd0);

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].key, vecs[v].bp, vecs[v].inj);
            chk($sformatf("v%0d_rk0", v), got[0], vecs[v].key);
            chk($sformatf("v%0d_rk1", v), got[1], vecs[v].rk1);
            chk($sformatf("v%0d_rk10", v), got[10], vecs[v].rk10);
            if (!vecs[v].bp)
                chk($sformatf("v%0d_done_cyc", v), 128'(done_cyc), 128'd12);
            if (vecs[v].key == FIPS)
                for (int r = 2; r < 10; r++)
                    chk($sformatf("v%0d_rk%0d", v, r), got[r], fips_rk[r]);
        end

        // Reset in the middle of the sequence.
        @(negedge clk);
        key_in = FIPS;
        key_valid = 1'b1;
        round_key_ready = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
        for (int c = 0; c < 40 && round_idx != 4'd5; c++) @(negedge clk);
        chk("reach_idx5", 128'(round_idx), 128'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(round_key_valid), 128'd0);
        chk("midrst_key", round_key, 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 128'(done), 128'd0);
        run_seq(FIPS, 1'b0, 1'b0);
        for (int r = 0; r < 11; r++)
            chk($sformatf("postrst_rk%0d", r), got[r], fips_rk[r]);

`ifdef AES_KEY_STORE_EN
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rk_rd_addr = 4'(a);
            @(negedge clk);
            chk($sformatf("store_a%0d", a), rk_rd_data,
                (a <= 10) ? fips_rk[a] : 128'd0);
        end
`else
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rk_rd_addr = 4'(a);
            @(negedge clk);
            chk($sformatf("nostore_a%0d", a), rk_rd_data, 128'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
